// File: rtl/bcd_pkg.sv
// Shared constants and state encoding for the serial binary-to-BCD converter.
package bcd_pkg;

    localparam int unsigned DIGIT_W  = 4;
    localparam logic [3:0]  BCD_NINE = 4'h9;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

endpackage

// File: rtl/bin2bcd_serial_if.sv
// Handshake and result bundle between the display counter and the BCD converter.
interface bin2bcd_serial_if
    import bcd_pkg::*;
#(
    parameter int unsigned BIN_W  = 10,
    parameter int unsigned DIGITS = 3
);

    logic                        in_valid;
    logic                        in_ready;
    logic [BIN_W-1:0]            in_bin;
    logic                        out_valid;
    logic [DIGIT_W*DIGITS-1:0]   out_bcd;
    logic                        overflow;

    modport master (
        output in_valid, in_bin,
        input  in_ready, out_valid, out_bcd, overflow
    );

    modport slave (
        input  in_valid, in_bin,
        output in_ready, out_valid, out_bcd, overflow
    );

endinterface

// File: rtl/bcd_digit_adj.sv
// One BCD digit pre-shift correction: values 5..9 get +3 so the next shift carries correctly.
module bcd_digit_adj
    import bcd_pkg::*;
(
    input  logic [DIGIT_W-1:0] din,
    output logic [DIGIT_W-1:0] dout_c
);

    // Add 3 within the digit; never carries into the neighbour.
    always_comb begin
        dout_c = din;
        if (din >= DIGIT_W'(5)) begin
            dout_c = din + DIGIT_W'(3);
        end
    end

endmodule

// File: rtl/bin2bcd_serial.sv
// Serial double-dabble binary-to-BCD converter, one input bit per clock.
// Optional build macro BCD_SATURATE_EN: overflowing results show as all 9s.
module bin2bcd_serial
    import bcd_pkg::*;
#(
    parameter int unsigned BIN_W  = 10,
    parameter int unsigned DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  RESET,
    bin2bcd_serial_if.slave       bus
);

    localparam int unsigned BCD_W = DIGIT_W * DIGITS;
    localparam int unsigned CNT_W = $clog2(BIN_W + 1);

    state_e             state_q,     state_d;
    logic [BIN_W-1:0]   shift_bin_q, shift_bin_d;
    logic [BCD_W-1:0]   scratch_q,   scratch_d;
    logic               sticky_q,    sticky_d;
    logic [CNT_W-1:0]   cnt_q,       cnt_d;
    logic [BCD_W-1:0]   out_bcd_q,   out_bcd_d;
    logic               overflow_q,  overflow_d;
    logic               out_valid_q, out_valid_d;
    logic [BCD_W-1:0]   adj_c;
    logic [BCD_W-1:0]   result_c;

    // Per-digit add-3 correction of the scratch register.
    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_digit_adj u_adj (
            .din    (scratch_q[g*DIGIT_W +: DIGIT_W]),
            .dout_c (adj_c[g*DIGIT_W +: DIGIT_W])
        );
    end

    // Value published at DONE; saturated build replaces overflowing results with all 9s.
`ifdef BCD_SATURATE_EN
    assign result_c = sticky_q ? {DIGITS{BCD_NINE}} : scratch_q;
`else
    assign result_c = scratch_q;
`endif

    // State register and datapath flops, synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!RESET) begin
            state_q     <= ST_IDLE;
            shift_bin_q <= '0;
            scratch_q   <= '0;
            sticky_q    <= 1'b0;
            cnt_q       <= '0;
            out_bcd_q   <= '0;
            overflow_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            shift_bin_q <= shift_bin_d;
            scratch_q   <= scratch_d;
            sticky_q    <= sticky_d;
            cnt_q       <= cnt_d;
            out_bcd_q   <= out_bcd_d;
            overflow_q  <= overflow_d;
            out_valid_q <= out_valid_d;
        end
    end

    // Next-state and datapath updates; published result changes only in DONE.
    always_comb begin
        state_d     = state_q;
        shift_bin_d = shift_bin_q;
        scratch_d   = scratch_q;
        sticky_d    = sticky_q;
        cnt_d       = cnt_q;
        out_bcd_d   = out_bcd_q;
        overflow_d  = overflow_q;
        out_valid_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.in_valid) begin
                    shift_bin_d = bus.in_bin;
                    scratch_d   = '0;
                    sticky_d    = 1'b0;
                    cnt_d       = CNT_W'(BIN_W);
                    state_d     = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                scratch_d   = {adj_c[BCD_W-2:0], shift_bin_q[BIN_W-1]};
                shift_bin_d = shift_bin_q << 1;
                sticky_d    = sticky_q | adj_c[BCD_W-1];
                cnt_d       = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                out_bcd_d   = result_c;
                overflow_d  = sticky_q;
                out_valid_d = 1'b1;
                state_d     = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign bus.in_ready  = (state_q == ST_IDLE);
    assign bus.out_valid = out_valid_q;
    assign bus.out_bcd   = out_bcd_q;
    assign bus.overflow  = overflow_q;

endmodule

// File: tb/tb_bin2bcd_serial.sv
// Self-checking bench for bin2bcd_serial: vector table, random values against a decimal model,
// and hand sequences for back-to-back, reset abort and result hold.
module tb_bin2bcd_serial;

    localparam int unsigned BIN_W  = 10;
    localparam int unsigned DIGITS = 3;
    localparam int unsigned BCD_W  = 4 * DIGITS;
`ifdef BCD_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    typedef struct {
        logic [BIN_W-1:0] bin;
        logic [BCD_W-1:0] exp_bcd;
        logic             exp_ovf;
    } vec_t;

    logic clk = 1'b0;
    logic RESET;
    always #5 clk = ~clk;

    bin2bcd_serial_if #(.BIN_W(BIN_W), .DIGITS(DIGITS)) bus ();

    bin2bcd_serial #(.BIN_W(BIN_W), .DIGITS(DIGITS)) dut (
        .clk   (clk),
        .RESET (RESET),
        .bus   (bus)
    );

    int checks   = 0;
    int failures = 0;
    logic [BCD_W-1:0] held_bcd;
    logic             held_ovf;
    vec_t vecs [12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Decimal reference: digits of v mod 10^DIGITS, or all nines when saturating.
    function automatic logic [BCD_W-1:0] model_bcd(input int v);
        logic [BCD_W-1:0] b;
        int r;
        if (SAT && v >= 1000) return {DIGITS{4'h9}};
        r = v % 1000;
        b = '0;
        for (int i = 0; i < int'(DIGITS); i++) begin
            b[4*i +: 4] = 4'(r % 10);
            r = r / 10;
        end
        return b;
    endfunction

    // One full conversion: latency, ready window, result hold and pulse width all checked.
    task automatic convert(input logic [BIN_W-1:0] bin, input logic [BCD_W-1:0] exp_bcd,
                           input logic exp_ovf, input string name);
        int n;
        int low_cycles;
        bit seen;
        bit hold_ok;
        @(negedge clk);
        chk({name, " ready_before"}, 32'(bus.in_ready), 32'd1);
        bus.in_valid = 1'b1;
        bus.in_bin   = bin;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.in_bin   = BIN_W'($urandom);
        n = 0; low_cycles = 0; seen = 1'b0; hold_ok = 1'b1;
        while (n < 40 && !seen) begin
            if (bus.out_valid === 1'b1) begin
                seen = 1'b1;
            end else begin
                if (bus.out_bcd !== held_bcd || bus.overflow !== held_ovf) hold_ok = 1'b0;
                if (bus.in_ready !== 1'b1) low_cycles++;
                n++;
                @(negedge clk);
                bus.in_bin   = BIN_W'($urandom);
                bus.in_valid = (n < 11) ? 1'($urandom) : 1'b0;
            end
        end
        bus.in_valid = 1'b0;
        chk({name, " done_seen"}, 32'(seen), 32'd1);
        chk({name, " latency"}, 32'(n), 32'd11);
        chk({name, " busy_cycles"}, 32'(low_cycles), 32'd11);
        chk({name, " hold_during"}, 32'(hold_ok), 32'd1);
        chk({name, " bcd"}, 32'(bus.out_bcd), 32'(exp_bcd));
        chk({name, " ovf"}, 32'(bus.overflow), 32'(exp_ovf));
        chk({name, " ready_at_done"}, 32'(bus.in_ready), 32'd1);
        @(negedge clk);
        chk({name, " pulse_width"}, 32'(bus.out_valid), 32'd0);
        held_bcd = exp_bcd;
        held_ovf = exp_ovf;
    endtask

    initial begin
        int c;
        int np;
        int pc [2];
        logic [BCD_W-1:0] pv [2];
        bit ok;
        int v;

        vecs[0]  = '{10'd0,    12'h000, 1'b0};
        vecs[1]  = '{10'd255,  12'h255, 1'b0};
        vecs[2]  = '{10'd999,  12'h999, 1'b0};
        vecs[3]  = '{10'd1000, SAT ? 12'h999 : 12'h000, 1'b1};
        vecs[4]  = '{10'd1023, SAT ? 12'h999 : 12'h023, 1'b1};
        vecs[5]  = '{10'd1,    12'h001, 1'b0};
        vecs[6]  = '{10'd9,    12'h009, 1'b0};
        vecs[7]  = '{10'd10,   12'h010, 1'b0};
        vecs[8]  = '{10'd99,   12'h099, 1'b0};
        vecs[9]  = '{10'd100,  12'h100, 1'b0};
        vecs[10] = '{10'd512,  12'h512, 1'b0};
        vecs[11] = '{10'd650,  12'h650, 1'b0};

        bus.in_valid = 1'b1;
        bus.in_bin   = 10'd300;
        RESET        = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset in_ready", 32'(bus.in_ready), 32'd1);
        chk("reset out_valid", 32'(bus.out_valid), 32'd0);
        chk("reset out_bcd", 32'(bus.out_bcd), 32'd0);
        chk("reset overflow", 32'(bus.overflow), 32'd0);
        bus.in_valid = 1'b0;
        RESET        = 1'b1;
        held_bcd = '0;
        held_ovf = 1'b0;

        // Table vectors.
        for (int i = 0; i < 12; i++) begin
            convert(vecs[i].bin, vecs[i].exp_bcd, vecs[i].exp_ovf, $sformatf("vec%0d", i));
        end

        // Result holds through a long idle stretch, then through the next conversion.
        convert(10'd255, 12'h255, 1'b0, "hold_src");
        ok = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (bus.out_bcd !== 12'h255 || bus.overflow !== 1'b0 || bus.out_valid !== 1'b0) ok = 1'b0;
        end
        chk("idle_hold", 32'(ok), 32'd1);
        convert(10'd999, 12'h999, 1'b0, "after_hold");

        // Back-to-back with in_valid held high; in_bin changes right after the first accept.
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_bin   = 10'd7;
        @(posedge clk);
        @(negedge clk);
        bus.in_bin = 10'd42;
        c = 0; np = 0; pc[0] = -1; pc[1] = -1; pv[0] = '0; pv[1] = '0;
        while (c < 60 && np < 2) begin
            if (bus.out_valid === 1'b1) begin
                pc[np] = c;
                pv[np] = bus.out_bcd;
                np++;
            end
            if (np < 2) begin
                @(negedge clk);
                c++;
                if (np >= 1 && c == pc[0] + 1) bus.in_valid = 1'b0;
            end
        end
        bus.in_valid = 1'b0;
        chk("b2b pulses", 32'(np), 32'd2);
        chk("b2b first_latency", 32'(pc[0]), 32'd11);
        chk("b2b spacing", 32'(pc[1] - pc[0]), 32'd12);
        chk("b2b first_bcd", 32'(pv[0]), 32'h007);
        chk("b2b second_bcd", 32'(pv[1]), 32'h042);
        @(negedge clk);
        chk("b2b pulse_end", 32'(bus.out_valid), 32'd0);
        held_bcd = 12'h042;
        held_ovf = 1'b0;

        // Reset on the 5th shift edge of 512 aborts silently and clears the result.
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_bin   = 10'd512;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (4) @(negedge clk);
        RESET        = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_bin   = 10'd77;
        @(negedge clk);
        chk("abort out_bcd", 32'(bus.out_bcd), 32'd0);
        chk("abort overflow", 32'(bus.overflow), 32'd0);
        chk("abort in_ready", 32'(bus.in_ready), 32'd1);
        chk("abort out_valid", 32'(bus.out_valid), 32'd0);
        RESET        = 1'b1;
        bus.in_valid = 1'b0;
        ok = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.out_valid !== 1'b0 || bus.out_bcd !== 12'h000 || bus.in_ready !== 1'b1) ok = 1'b0;
        end
        chk("abort quiet", 32'(ok), 32'd1);
        held_bcd = '0;
        held_ovf = 1'b0;
        convert(10'd123, 12'h123, 1'b0, "post_abort");

        // Random values against the decimal model.
        for (int i = 0; i < 40; i++) begin
            v = int'($urandom_range(0, 1023));
            convert(BIN_W'(v), model_bcd(v), (v >= 1000), $sformatf("rand%0d_%0d", i, v));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
